// File: rtl/wb_byte_initiator_if.sv
// Byte-stream command/response and Wishbone initiator signals of wb_byte_initiator.
// master = the initiator itself; slave = host byte link plus Wishbone responder.
interface wb_byte_initiator_if;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic        o_rx_ready;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready;
  logic [31:0] o_wb_adr;
  logic [31:0] o_wb_dat;
  logic [3:0]  o_wb_sel;
  logic        o_wb_we;
  logic        o_wb_cyc;
  logic [31:0] i_wb_rdt;
  logic        i_wb_ack;
  logic        o_hold;

  modport master (
    input  i_rx_data, i_rx_valid, i_tx_ready, i_wb_rdt, i_wb_ack,
    output o_rx_ready, o_tx_data, o_tx_valid, o_wb_adr, o_wb_dat, o_wb_sel,
           o_wb_we, o_wb_cyc, o_hold
  );

  modport slave (
    output i_rx_data, i_rx_valid, i_tx_ready, i_wb_rdt, i_wb_ack,
    input  o_rx_ready, o_tx_data, o_tx_valid, o_wb_adr, o_wb_dat, o_wb_sel,
           o_wb_we, o_wb_cyc, o_hold
  );
endinterface

// File: rtl/wb_byte_initiator.sv
// Wishbone initiator driven by byte-stream W/R/H/G command frames; holds the CPU while loading.
// Optional ack timeout enabled by defining WB_BYTE_INITIATOR_TIMEOUT_EN (uses TIMEOUT, min 2).
module wb_byte_initiator #(
  parameter int TIMEOUT = 1024
) (
  input logic                 wb_clk,
  input logic                 wb_rst_n,
  wb_byte_initiator_if.master bus
);

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] OP_HOLD  = 8'h48;
  localparam logic [7:0] OP_GO    = 8'h47;
  localparam logic [7:0] RSP_OK   = 8'h4B;
  localparam logic [7:0] RSP_BAD  = 8'h3F;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    BUS,
    RESP
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  last_q, last_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [31:0] resp_q, resp_d;
  logic        we_q, we_d;
  logic        cyc_q, cyc_d;
  logic        rx_ready_q, rx_ready_d;
  logic        tx_valid_q, tx_valid_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        hold_q, hold_d;
  logic        rx_fire;
  logic        tx_fire;

`ifdef WB_BYTE_INITIATOR_TIMEOUT_EN
  localparam logic [7:0] RSP_TMO = 8'h54;
  localparam int         TMO_W   = $clog2(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

  assign rx_fire = bus.i_rx_valid && rx_ready_q;
  assign tx_fire = tx_valid_q && bus.i_tx_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    resp_d     = resp_q;
    we_d       = we_q;
    cyc_d      = cyc_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    hold_d     = hold_q;
`ifdef WB_BYTE_INITIATOR_TIMEOUT_EN
    tmo_d      = tmo_q;
`endif
    case (state_q)
      IDLE: begin
        if (rx_fire) begin
          cnt_d  = 2'd0;
          last_d = 2'd0;
          case (bus.i_rx_data)
            OP_WRITE: begin we_d = 1'b1; state_d = ADDR; end
            OP_READ:  begin we_d = 1'b0; state_d = ADDR; end
            OP_HOLD:  begin hold_d = 1'b1; resp_d = {24'h0, RSP_OK}; state_d = RESP; end
            OP_GO:    begin hold_d = 1'b0; resp_d = {24'h0, RSP_OK}; state_d = RESP; end
            default:  begin resp_d = {24'h0, RSP_BAD}; state_d = RESP; end
          endcase
        end
      end
      // Fields arrive LSB-first: each byte enters at the top and the word slides down.
      ADDR: begin
        if (rx_fire) begin
          adr_d = {bus.i_rx_data, adr_q[31:8]};
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = we_q ? DATA : BUS;
        end
      end
      DATA: begin
        if (rx_fire) begin
          dat_d = {bus.i_rx_data, dat_q[31:8]};
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = BUS;
        end
      end
      BUS: begin
        if (!cyc_q) begin
          cyc_d = 1'b1;
`ifdef WB_BYTE_INITIATOR_TIMEOUT_EN
          tmo_d = '0;
`endif
        end else if (bus.i_wb_ack) begin
          cyc_d   = 1'b0;
          resp_d  = we_q ? {24'h0, RSP_OK} : bus.i_wb_rdt;
          last_d  = we_q ? 2'd0 : 2'd3;
          state_d = RESP;
        end
`ifdef WB_BYTE_INITIATOR_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          cyc_d   = 1'b0;
          resp_d  = {24'h0, RSP_TMO};
          last_d  = 2'd0;
          state_d = RESP;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
`endif
      end
      // First clock loads the byte register; afterwards each accepted byte shifts the next one in.
      RESP: begin
        if (!tx_valid_q) begin
          tx_valid_d = 1'b1;
          tx_data_d  = resp_q[7:0];
        end else if (tx_fire) begin
          if (cnt_q == last_q) begin
            tx_valid_d = 1'b0;
            cnt_d      = 2'd0;
            state_d    = IDLE;
          end else begin
            tx_data_d = resp_q[15:8];
            resp_d    = {8'h0, resp_q[31:8]};
            cnt_d     = cnt_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    rx_ready_d = (state_d == IDLE) || (state_d == ADDR) || (state_d == DATA);
  end

  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 2'd0;
      last_q     <= 2'd0;
      adr_q      <= 32'h0;
      dat_q      <= 32'h0;
      resp_q     <= 32'h0;
      we_q       <= 1'b0;
      cyc_q      <= 1'b0;
      rx_ready_q <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h0;
      hold_q     <= 1'b1;
`ifdef WB_BYTE_INITIATOR_TIMEOUT_EN
      tmo_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      resp_q     <= resp_d;
      we_q       <= we_d;
      cyc_q      <= cyc_d;
      rx_ready_q <= rx_ready_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      hold_q     <= hold_d;
`ifdef WB_BYTE_INITIATOR_TIMEOUT_EN
      tmo_q      <= tmo_d;
`endif
    end
  end

  assign bus.o_rx_ready = rx_ready_q;
  assign bus.o_tx_valid = tx_valid_q;
  assign bus.o_tx_data  = tx_data_q;
  assign bus.o_wb_adr   = adr_q;
  assign bus.o_wb_dat   = dat_q;
  assign bus.o_wb_sel   = 4'hF;
  assign bus.o_wb_we    = we_q;
  assign bus.o_wb_cyc   = cyc_q;
  assign bus.o_hold     = hold_q;

endmodule

// File: tb/tb_wb_byte_initiator.sv
// Directed bench for wb_byte_initiator: frames, zero/multi-wait responders, tx stall, reset abort, timeout.
module tb_wb_byte_initiator;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;
  int   cyc_clks = 0;

  wb_byte_initiator_if ifc();

  wb_byte_initiator #(.TIMEOUT(8)) dut (
    .wb_clk  (clk),
    .wb_rst_n(rst_n),
    .bus     (ifc)
  );

  always #5 clk = ~clk;

  // Number of clock periods during which cyc was high.
  always @(posedge clk) if (ifc.o_wb_cyc === 1'b1) cyc_clks <= cyc_clks + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    ifc.i_rx_data  = b;
    ifc.i_rx_valid = 1'b1;
    while (ifc.o_rx_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) check("rx_ready_wait", ifc.o_rx_ready, 1);
    @(negedge clk);
    ifc.i_rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic wb_serve(input int waits, input logic [31:0] rdt, input logic [31:0] exp_adr,
                          input logic [31:0] exp_dat, input logic exp_we, input string tag);
    int n;
    n = 0;
    while (ifc.o_wb_cyc !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check({tag, "_cyc_up"}, ifc.o_wb_cyc, 1);
    check({tag, "_adr"}, ifc.o_wb_adr, exp_adr);
    check({tag, "_we"}, ifc.o_wb_we, exp_we);
    check({tag, "_sel"}, ifc.o_wb_sel, 4'hF);
    if (exp_we) check({tag, "_dat"}, ifc.o_wb_dat, exp_dat);
    for (int i = 0; i < waits; i++) @(negedge clk);
    check({tag, "_adr_hold"}, ifc.o_wb_adr, exp_adr);
    ifc.i_wb_rdt = rdt;
    ifc.i_wb_ack = 1'b1;
    @(negedge clk);
    ifc.i_wb_ack = 1'b0;
    ifc.i_wb_rdt = 32'h0;
    check({tag, "_cyc_drop"}, ifc.o_wb_cyc, 0);
  endtask

  task automatic recv_check(input logic [31:0] exp, input int nbytes, input string tag);
    int n;
    for (int i = 0; i < nbytes; i++) begin
      n = 0;
      while (ifc.o_tx_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      check($sformatf("%s_vld%0d", tag, i), ifc.o_tx_valid, 1);
      check($sformatf("%s_tx%0d", tag, i), ifc.o_tx_data, exp[8*i +: 8]);
      @(negedge clk);
    end
    check({tag, "_tx_done"}, ifc.o_tx_valid, 0);
  endtask

  initial begin
    int base;
    int n;
    int tx_seen;
    ifc.i_rx_data  = 8'h0;
    ifc.i_rx_valid = 1'b0;
    ifc.i_tx_ready = 1'b1;
    ifc.i_wb_rdt   = 32'h0;
    ifc.i_wb_ack   = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_rx_ready", ifc.o_rx_ready, 0);
    check("rst_tx_valid", ifc.o_tx_valid, 0);
    check("rst_tx_data", ifc.o_tx_data, 0);
    check("rst_cyc", ifc.o_wb_cyc, 0);
    check("rst_we", ifc.o_wb_we, 0);
    check("rst_adr", ifc.o_wb_adr, 0);
    check("rst_dat", ifc.o_wb_dat, 0);
    check("rst_hold", ifc.o_hold, 1);
    rst_n = 1'b1;
    @(negedge clk);
    check("rx_ready_after_rst", ifc.o_rx_ready, 1);

    // 1: write frame, zero-wait ack, 3-clock latency to first response byte
    base = cyc_clks;
    send_byte(8'h57);
    send_word(32'h0000_0100);
    send_word(32'hDEAD_BEEF);
    check("wr_rx_ready_low", ifc.o_rx_ready, 0);
    @(negedge clk);
    check("wr_cyc_up", ifc.o_wb_cyc, 1);
    check("wr_adr", ifc.o_wb_adr, 32'h0000_0100);
    check("wr_dat", ifc.o_wb_dat, 32'hDEAD_BEEF);
    check("wr_we", ifc.o_wb_we, 1);
    check("wr_sel", ifc.o_wb_sel, 4'hF);
    ifc.i_wb_ack = 1'b1;
    @(negedge clk);
    ifc.i_wb_ack = 1'b0;
    check("wr_cyc_drop", ifc.o_wb_cyc, 0);
    check("wr_tx_not_yet", ifc.o_tx_valid, 0);
    @(negedge clk);
    check("wr_latency3", ifc.o_tx_valid, 1);
    recv_check(32'h4B, 1, "wr_resp");
    check("wr_one_cycle", cyc_clks - base, 1);

    // 2: read frame, responder waits 3 clocks
    base = cyc_clks;
    send_byte(8'h52);
    send_word(32'h0000_0100);
    wb_serve(3, 32'hDEAD_BEEF, 32'h0000_0100, 32'h0, 1'b0, "rd");
    check("rd_cyc_clks", cyc_clks - base, 4);
    recv_check(32'hDEAD_BEEF, 4, "rd_resp");

    // 3: go / hold / unknown opcode; stray ack while idle is ignored
    send_byte(8'h47);
    recv_check(32'h4B, 1, "go_resp");
    check("go_hold", ifc.o_hold, 0);
    send_byte(8'h48);
    recv_check(32'h4B, 1, "hold_resp");
    check("hold_hold", ifc.o_hold, 1);
    base = cyc_clks;
    ifc.i_wb_ack = 1'b1;
    @(negedge clk);
    ifc.i_wb_ack = 1'b0;
    send_byte(8'h00);
    recv_check(32'h3F, 1, "bad_resp");
    check("bad_no_cyc", cyc_clks - base, 0);

    // 4: sink stalls 20 clocks during a read response
    send_byte(8'h52);
    send_word(32'h0000_0004);
    ifc.i_tx_ready = 1'b0;
    wb_serve(0, 32'h1234_5678, 32'h0000_0004, 32'h0, 1'b0, "stall");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("stall_vld", ifc.o_tx_valid, 1);
      check("stall_data", ifc.o_tx_data, 8'h78);
      check("stall_rx_ready", ifc.o_rx_ready, 0);
    end
    ifc.i_tx_ready = 1'b1;
    recv_check(32'h1234_5678, 4, "stall_resp");

    // 5: reset pulse while cyc is high aborts the write and re-asserts hold
    send_byte(8'h47);
    recv_check(32'h4B, 1, "go2_resp");
    check("go2_hold", ifc.o_hold, 0);
    send_byte(8'h57);
    send_word(32'h0000_0300);
    send_word(32'h0BAD_F00D);
    n = 0;
    while (ifc.o_wb_cyc !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check("abort_cyc_up", ifc.o_wb_cyc, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_cyc", ifc.o_wb_cyc, 0);
    check("abort_hold", ifc.o_hold, 1);
    check("abort_tx_valid", ifc.o_tx_valid, 0);
    check("abort_rx_ready", ifc.o_rx_ready, 0);
    tx_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ifc.o_tx_valid === 1'b1) tx_seen++;
    end
    check("abort_no_tx", tx_seen, 0);
    send_byte(8'h52);
    send_word(32'h0000_0200);
    wb_serve(1, 32'hCAFE_F00D, 32'h0000_0200, 32'h0, 1'b0, "post_rst");
    recv_check(32'hCAFE_F00D, 4, "post_rst_resp");

    // 6: read with no ack ever
    base = cyc_clks;
    send_byte(8'h52);
    send_word(32'h0000_0400);
`ifdef WB_BYTE_INITIATOR_TIMEOUT_EN
    n = 0;
    while (ifc.o_tx_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    check("tmo_cyc_clks", cyc_clks - base, 8);
    check("tmo_cyc_low", ifc.o_wb_cyc, 0);
    recv_check(32'h54, 1, "tmo_resp");
`else
    repeat (40) @(negedge clk);
    check("notmo_cyc_high", ifc.o_wb_cyc, 1);
    check("notmo_no_tx", ifc.o_tx_valid, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("notmo_rst_cyc", ifc.o_wb_cyc, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
